// File: rtl/ultrasonic_cu_mc_pkg.sv
// Shared types for the multi-channel ultrasonic control unit: opcodes, channel states, level ceiling.
// No logic of its own, so no latency.
// No flow control; it holds type and constant definitions only.
package cu_mc_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_ON    = 3'd1,
        OP_OFF   = 3'd2,
        OP_INC   = 3'd3,
        OP_DEC   = 3'd4,
        OP_SEND  = 3'd5,
        OP_RECV  = 3'd6,
        OP_CLEAR = 3'd7
    } cu_op_t;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_IDLE = 2'd1,
        ST_SEND = 2'd2,
        ST_RECV = 2'd3
    } ch_state_t;

    // Largest level a DAC of the given width can take; INC saturates here.
    function automatic int unsigned dac_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/ultrasonic_cu_mc_if.sv
// Bundles the command, buffer, AXI, DAC and capture-read signals of the control unit.
// No logic of its own, so no latency.
// No backpressure: every strobe is accepted in the cycle it is presented.
interface ultrasonic_cu_mc_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 25,
    parameter int DAC_W  = 12,
    parameter int AMT_W  = 8,
    parameter int DEPTH  = 128
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int AW   = $clog2(DEPTH);

    logic                   cmd_valid;
    logic [CH_W-1:0]        cmd_ch;
    logic [2:0]             cmd_op;
    logic [AMT_W-1:0]       cmd_amount;
    logic                   cmd_err;
    logic                   buf_valid;
    logic [DATA_W-1:0]      buf_data;
    logic [DATA_W-1:0]      axi_out;
    logic                   axi_valid;
    logic                   sending;
    logic                   no_order;
    logic [N_CH*DAC_W-1:0]  dac_out;
    logic [CH_W-1:0]        act_ch;
    logic                   rd_en;
    logic [AW-1:0]          rd_addr;
    logic [DATA_W-1:0]      rd_data;
    logic [AW:0]            cap_count;
    logic                   cap_full;
    logic                   cap_ovf;

    modport master (
        output cmd_valid, cmd_ch, cmd_op, cmd_amount, buf_valid, buf_data, rd_en, rd_addr,
        input  cmd_err, axi_out, axi_valid, sending, no_order, dac_out, act_ch,
               rd_data, cap_count, cap_full, cap_ovf
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_op, cmd_amount, buf_valid, buf_data, rd_en, rd_addr,
        output cmd_err, axi_out, axi_valid, sending, no_order, dac_out, act_ch,
               rd_data, cap_count, cap_full, cap_ovf
    );

endinterface

// File: rtl/ultrasonic_cu_mc_capture_ram.sv
// Capture RAM: DEPTH x DATA_W, one write port, one registered read port, read-before-write.
// Read data appears one cycle after rd_en; writes land at the clock edge.
// No backpressure; rd_data holds while rd_en is low.
module cu_capture_ram #(
    parameter int DEPTH  = 128,
    parameter int DATA_W = 25,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array is never cleared; a write during reset is suppressed so reset aborts capture.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; sampling mem before the write commits gives old data on a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ultrasonic_cu_mc.sv
// Multi-channel ultrasonic control unit: per-channel FSM and DAC level, send/receive data routing.
// Commands and buffer samples take effect one cycle later; capture reads have one-cycle latency.
// No backpressure: commands and samples are always accepted; bad commands pulse cmd_err.
module ultrasonic_cu_mc
    import cu_mc_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int DATA_W    = 25,
    parameter int DAC_W     = 12,
    parameter int AMT_W     = 8,
    parameter int AMT_SHIFT = 4,
    parameter int DEPTH     = 128,
    parameter int WRAP      = 0
) (
    input logic               clk,
    input logic               rst,
    ultrasonic_cu_mc_if.slave bus
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int AW   = $clog2(DEPTH);
    localparam logic [DAC_W:0] LVL_MAX = (DAC_W+1)'(dac_max(DAC_W));

    ch_state_t        st  [N_CH];
    logic [DAC_W-1:0] lvl [N_CH];
    logic [CH_W-1:0]  act_ch_q;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      cap_count_q;

    cu_op_t           op;
    logic             ch_ok;
    ch_state_t        act_state;
    logic [DAC_W:0]   step, cur, sum, diff;
    logic [DAC_W-1:0] inc_lvl, dec_lvl;
    logic             all_off, clear_cmd, cap_sample, full, wr_en;

    assign op        = cu_op_t'(bus.cmd_op);
    assign ch_ok     = (32'(bus.cmd_ch) < N_CH);
    assign act_state = st[act_ch_q];
    assign full      = (cap_count_q == (AW+1)'(DEPTH));
    assign clear_cmd = bus.cmd_valid && ch_ok && (op == OP_CLEAR);
    assign cap_sample = bus.buf_valid && (act_state == ST_RECV);
    assign wr_en     = cap_sample && !clear_cmd && (!full || (WRAP != 0));

    // Saturating level arithmetic on the addressed channel, one bit wider than the DAC.
    always_comb begin
        step    = (DAC_W+1)'(bus.cmd_amount) << AMT_SHIFT;
        cur     = {1'b0, lvl[bus.cmd_ch]};
        sum     = cur + step;
        diff    = cur - step;
        inc_lvl = (sum > LVL_MAX) ? LVL_MAX[DAC_W-1:0] : sum[DAC_W-1:0];
        dec_lvl = (cur >= step) ? diff[DAC_W-1:0] : '0;
    end

    // no_order is true only while every channel sits in OFF.
    always_comb begin
        all_off = 1'b1;
        for (int k = 0; k < N_CH; k++) begin
            if (st[k] != ST_OFF) all_off = 1'b0;
        end
    end

    // Pack per-channel levels, channel k in bits [k*DAC_W +: DAC_W].
    always_comb begin
        bus.dac_out = '0;
        for (int k = 0; k < N_CH; k++) begin
            bus.dac_out[k*DAC_W +: DAC_W] = lvl[k];
        end
    end

    assign bus.sending   = (act_state == ST_SEND);
    assign bus.no_order  = all_off;
    assign bus.act_ch    = act_ch_q;
    assign bus.cap_count = cap_count_q;
    assign bus.cap_full  = full;

    // Channel FSMs, levels and data-path ownership; only one channel may be in SEND/RECV.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                st[k]  <= ST_OFF;
                lvl[k] <= '0;
            end
            act_ch_q    <= '0;
            bus.cmd_err <= 1'b0;
        end else begin
            bus.cmd_err <= 1'b0;
            if (bus.cmd_valid) begin
                if (!ch_ok) begin
                    bus.cmd_err <= 1'b1;
                end else begin
                    case (op)
                        OP_ON: begin
                            if (st[bus.cmd_ch] == ST_OFF) st[bus.cmd_ch] <= ST_IDLE;
                        end
                        OP_OFF: begin
                            st[bus.cmd_ch]  <= ST_OFF;
                            lvl[bus.cmd_ch] <= '0;
                        end
                        OP_INC, OP_DEC: begin
                            if (st[bus.cmd_ch] == ST_OFF) bus.cmd_err <= 1'b1;
                            else lvl[bus.cmd_ch] <= (op == OP_INC) ? inc_lvl : dec_lvl;
                        end
                        OP_SEND, OP_RECV: begin
                            if (st[bus.cmd_ch] == ST_OFF) begin
                                bus.cmd_err <= 1'b1;
                            end else begin
                                if (act_ch_q != bus.cmd_ch &&
                                    (act_state == ST_SEND || act_state == ST_RECV)) begin
                                    st[act_ch_q] <= ST_IDLE;
                                end
                                st[bus.cmd_ch] <= (op == OP_SEND) ? ST_SEND : ST_RECV;
                                act_ch_q       <= bus.cmd_ch;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // AXI forwarding and capture bookkeeping, both driven by the pre-command channel state.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.axi_out   <= '0;
            bus.axi_valid <= 1'b0;
            wr_ptr        <= '0;
            cap_count_q   <= '0;
            bus.cap_ovf   <= 1'b0;
        end else begin
            bus.axi_valid <= 1'b0;
            if (bus.buf_valid && act_state == ST_SEND) begin
                bus.axi_out   <= bus.buf_data;
                bus.axi_valid <= 1'b1;
            end
            if (clear_cmd) begin
                wr_ptr      <= '0;
                cap_count_q <= '0;
                bus.cap_ovf <= 1'b0;
            end else if (cap_sample) begin
                if (full) bus.cap_ovf <= 1'b1;
                if (wr_en) wr_ptr <= wr_ptr + 1'b1;
                if (!full) cap_count_q <= cap_count_q + 1'b1;
            end
        end
    end

    cu_capture_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (bus.buf_data),
        .rd_en   (bus.rd_en),
        .rd_addr (bus.rd_addr),
        .rd_data (bus.rd_data)
    );

endmodule

// File: tb/tb_ultrasonic_cu_mc.sv
// Directed bench for the control unit: one instance with stop-at-full capture and four channels,
// one with circular capture and three channels so an out-of-range channel number can be driven.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_ultrasonic_cu_mc;
    import cu_mc_pkg::*;

    logic clk = 1'b0;
    logic rst0, rst1;
    int   pass_cnt = 0;
    int   check_cnt = 0;

    always #5 clk = ~clk;

    ultrasonic_cu_mc_if #(.N_CH(4)) bus0 ();
    ultrasonic_cu_mc_if #(.N_CH(3)) bus1 ();

    ultrasonic_cu_mc #(.N_CH(4), .WRAP(0)) u0 (.clk(clk), .rst(rst0), .bus(bus0));
    ultrasonic_cu_mc #(.N_CH(3), .WRAP(1)) u1 (.clk(clk), .rst(rst1), .bus(bus1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input bit u, input int ch, input cu_op_t op, input int amt);
        if (u) begin
            bus1.cmd_valid = 1'b1; bus1.cmd_ch = 2'(ch); bus1.cmd_op = op; bus1.cmd_amount = 8'(amt);
        end else begin
            bus0.cmd_valid = 1'b1; bus0.cmd_ch = 2'(ch); bus0.cmd_op = op; bus0.cmd_amount = 8'(amt);
        end
        tick();
        bus0.cmd_valid = 1'b0;
        bus1.cmd_valid = 1'b0;
    endtask

    task automatic stream(input bit u, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            if (u) begin bus1.buf_valid = 1'b1; bus1.buf_data = 25'(first + i); end
            else   begin bus0.buf_valid = 1'b1; bus0.buf_data = 25'(first + i); end
            tick();
        end
        bus0.buf_valid = 1'b0;
        bus1.buf_valid = 1'b0;
    endtask

    task automatic rd(input bit u, input int addr);
        if (u) begin bus1.rd_en = 1'b1; bus1.rd_addr = 7'(addr); end
        else   begin bus0.rd_en = 1'b1; bus0.rd_addr = 7'(addr); end
        tick();
        bus0.rd_en = 1'b0;
        bus1.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1;
        tick(); tick();
        rst0 = 1'b0; rst1 = 1'b0;
        check_cnt++; if (bus0.no_order !== 1'b1) $display("FAIL reset_no_order got %0b want 1", bus0.no_order); else pass_cnt++;
        check_cnt++; if (bus0.dac_out !== 48'h0) $display("FAIL reset_dac got %h want 0", bus0.dac_out); else pass_cnt++;
        check_cnt++; if (bus0.axi_valid !== 1'b0 || bus0.sending !== 1'b0 || bus0.cmd_err !== 1'b0)
            $display("FAIL reset_flags got axi_valid=%0b sending=%0b cmd_err=%0b want 0 0 0", bus0.axi_valid, bus0.sending, bus0.cmd_err); else pass_cnt++;
        check_cnt++; if (bus0.cap_count !== 8'd0 || bus0.cap_ovf !== 1'b0 || bus0.rd_data !== 25'd0 || bus0.axi_out !== 25'd0)
            $display("FAIL reset_capture got count=%0d ovf=%0b rd=%h axi=%h want 0", bus0.cap_count, bus0.cap_ovf, bus0.rd_data, bus0.axi_out); else pass_cnt++;
        cmd(0, 1, OP_ON, 0);
        check_cnt++; if (bus0.no_order !== 1'b0) $display("FAIL on_no_order got %0b want 0", bus0.no_order); else pass_cnt++;
        cmd(0, 1, OP_OFF, 0);
        check_cnt++; if (bus0.no_order !== 1'b1) $display("FAIL off_no_order got %0b want 1", bus0.no_order); else pass_cnt++;
    endtask

    task automatic test_level();
        cmd(0, 0, OP_ON, 0);
        cmd(0, 0, OP_INC, 1);
        check_cnt++; if (bus0.dac_out !== 48'h000_000_000_010) $display("FAIL inc_1 got %h want 000000000010", bus0.dac_out); else pass_cnt++;
        cmd(0, 0, OP_INC, 8'hFF);
        check_cnt++; if (bus0.dac_out[11:0] !== 12'hFFF) $display("FAIL inc_sat1 got %h want fff", bus0.dac_out[11:0]); else pass_cnt++;
        cmd(0, 0, OP_INC, 8'hFF);
        check_cnt++; if (bus0.dac_out[11:0] !== 12'hFFF) $display("FAIL inc_sat2 got %h want fff", bus0.dac_out[11:0]); else pass_cnt++;
        cmd(0, 0, OP_DEC, 8'hFF);
        check_cnt++; if (bus0.dac_out[11:0] !== 12'h00F) $display("FAIL dec_1 got %h want 00f", bus0.dac_out[11:0]); else pass_cnt++;
        cmd(0, 0, OP_DEC, 8'hFF);
        check_cnt++; if (bus0.dac_out[11:0] !== 12'h000) $display("FAIL dec_floor got %h want 000", bus0.dac_out[11:0]); else pass_cnt++;
        cmd(0, 3, OP_INC, 5);
        check_cnt++; if (bus0.cmd_err !== 1'b1 || bus0.dac_out !== 48'h0)
            $display("FAIL inc_off_ch got err=%0b dac=%h want 1 0", bus0.cmd_err, bus0.dac_out); else pass_cnt++;
        cmd(0, 0, OP_INC, 3);
        check_cnt++; if (bus0.dac_out[11:0] !== 12'h030 || bus0.cmd_err !== 1'b0)
            $display("FAIL inc_3 got %h err=%0b want 030 0", bus0.dac_out[11:0], bus0.cmd_err); else pass_cnt++;
        cmd(0, 0, OP_OFF, 0);
        check_cnt++; if (bus0.dac_out !== 48'h0 || bus0.no_order !== 1'b1)
            $display("FAIL off_clears got dac=%h no_order=%0b want 0 1", bus0.dac_out, bus0.no_order); else pass_cnt++;
    endtask

    task automatic test_send();
        cmd(0, 2, OP_ON, 0);
        cmd(0, 2, OP_SEND, 0);
        check_cnt++; if (bus0.sending !== 1'b1 || bus0.act_ch !== 2'd2)
            $display("FAIL send_state got sending=%0b act=%0d want 1 2", bus0.sending, bus0.act_ch); else pass_cnt++;
        stream(0, 25'h0FFFFFF, 1);
        check_cnt++; if (bus0.axi_out !== 25'h0FFFFFF || bus0.axi_valid !== 1'b1)
            $display("FAIL send_fwd got axi=%h v=%0b want 0ffffff 1", bus0.axi_out, bus0.axi_valid); else pass_cnt++;
        tick();
        check_cnt++; if (bus0.axi_out !== 25'h0FFFFFF || bus0.axi_valid !== 1'b0)
            $display("FAIL send_hold got axi=%h v=%0b want 0ffffff 0", bus0.axi_out, bus0.axi_valid); else pass_cnt++;
        cmd(0, 3, OP_SEND, 0);
        check_cnt++; if (bus0.cmd_err !== 1'b1 || bus0.act_ch !== 2'd2 || bus0.sending !== 1'b1)
            $display("FAIL send_off_ch got err=%0b act=%0d sending=%0b want 1 2 1", bus0.cmd_err, bus0.act_ch, bus0.sending); else pass_cnt++;
        tick();
        check_cnt++; if (bus0.cmd_err !== 1'b0) $display("FAIL err_pulse got %0b want 0", bus0.cmd_err); else pass_cnt++;
        bus0.buf_valid = 1'b1; bus0.buf_data = 25'h123;
        cmd(0, 2, OP_OFF, 0);
        bus0.buf_valid = 1'b0;
        check_cnt++; if (bus0.axi_valid !== 1'b1 || bus0.axi_out !== 25'h123 || bus0.sending !== 1'b0)
            $display("FAIL send_precmd got v=%0b axi=%h sending=%0b want 1 123 0", bus0.axi_valid, bus0.axi_out, bus0.sending); else pass_cnt++;
    endtask

    task automatic test_capture_stop();
        cmd(0, 1, OP_ON, 0);
        cmd(0, 1, OP_RECV, 0);
        stream(0, 0, 130);
        check_cnt++; if (bus0.cap_count !== 8'd128 || bus0.cap_full !== 1'b1 || bus0.cap_ovf !== 1'b1)
            $display("FAIL stop_full got count=%0d full=%0b ovf=%0b want 128 1 1", bus0.cap_count, bus0.cap_full, bus0.cap_ovf); else pass_cnt++;
        rd(0, 127);
        check_cnt++; if (bus0.rd_data !== 25'd127) $display("FAIL stop_rd127 got %0d want 127", bus0.rd_data); else pass_cnt++;
        rd(0, 0);
        check_cnt++; if (bus0.rd_data !== 25'd0) $display("FAIL stop_rd0 got %0d want 0", bus0.rd_data); else pass_cnt++;
        bus0.rd_addr = 7'd5;
        tick();
        check_cnt++; if (bus0.rd_data !== 25'd0) $display("FAIL rd_hold got %0d want 0", bus0.rd_data); else pass_cnt++;
        bus0.buf_valid = 1'b1; bus0.buf_data = 25'h777;
        cmd(0, 1, OP_CLEAR, 0);
        bus0.buf_valid = 1'b0;
        check_cnt++; if (bus0.cap_count !== 8'd0 || bus0.cap_ovf !== 1'b0 || bus0.cap_full !== 1'b0)
            $display("FAIL clear got count=%0d ovf=%0b full=%0b want 0 0 0", bus0.cap_count, bus0.cap_ovf, bus0.cap_full); else pass_cnt++;
        stream(0, 25'hABC, 1);
        rd(0, 0);
        check_cnt++; if (bus0.cap_count !== 8'd1 || bus0.rd_data !== 25'hABC)
            $display("FAIL after_clear got count=%0d rd=%h want 1 abc", bus0.cap_count, bus0.rd_data); else pass_cnt++;
    endtask

    task automatic test_capture_wrap();
        cmd(1, 0, OP_ON, 0);
        cmd(1, 0, OP_RECV, 0);
        stream(1, 0, 130);
        check_cnt++; if (bus1.cap_count !== 8'd128 || bus1.cap_ovf !== 1'b1 || bus1.cap_full !== 1'b1)
            $display("FAIL wrap_count got count=%0d ovf=%0b full=%0b want 128 1 1", bus1.cap_count, bus1.cap_ovf, bus1.cap_full); else pass_cnt++;
        rd(1, 0);
        check_cnt++; if (bus1.rd_data !== 25'd128) $display("FAIL wrap_rd0 got %0d want 128", bus1.rd_data); else pass_cnt++;
        rd(1, 1);
        check_cnt++; if (bus1.rd_data !== 25'd129) $display("FAIL wrap_rd1 got %0d want 129", bus1.rd_data); else pass_cnt++;
        rd(1, 2);
        check_cnt++; if (bus1.rd_data !== 25'd2) $display("FAIL wrap_rd2 got %0d want 2", bus1.rd_data); else pass_cnt++;
        bus1.buf_valid = 1'b1; bus1.buf_data = 25'h555;
        rd(1, 2);
        bus1.buf_valid = 1'b0;
        check_cnt++; if (bus1.rd_data !== 25'd2) $display("FAIL rbw_old got %h want 2", bus1.rd_data); else pass_cnt++;
        rd(1, 2);
        check_cnt++; if (bus1.rd_data !== 25'h555) $display("FAIL rbw_new got %h want 555", bus1.rd_data); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        cmd(1, 0, OP_INC, 1);
        bus1.buf_valid = 1'b1; bus1.buf_data = 25'd7;
        tick();
        rst1 = 1'b1;
        tick();
        check_cnt++; if (bus1.cap_count !== 8'd0 || bus1.cap_ovf !== 1'b0 || bus1.sending !== 1'b0 || bus1.no_order !== 1'b1)
            $display("FAIL midrst_cap got count=%0d ovf=%0b sending=%0b no_order=%0b want 0 0 0 1", bus1.cap_count, bus1.cap_ovf, bus1.sending, bus1.no_order); else pass_cnt++;
        check_cnt++; if (bus1.dac_out !== 36'h0 || bus1.act_ch !== 2'd0 || bus1.rd_data !== 25'd0 || bus1.axi_valid !== 1'b0)
            $display("FAIL midrst_out got dac=%h act=%0d rd=%h axi_valid=%0b want 0", bus1.dac_out, bus1.act_ch, bus1.rd_data, bus1.axi_valid); else pass_cnt++;
        rst1 = 1'b0;
        tick();
        bus1.buf_valid = 1'b0;
        check_cnt++; if (bus1.cap_count !== 8'd0) $display("FAIL midrst_nocap got %0d want 0", bus1.cap_count); else pass_cnt++;
        rd(1, 2);
        check_cnt++; if (bus1.rd_data !== 25'h555) $display("FAIL ram_kept got %h want 555", bus1.rd_data); else pass_cnt++;
    endtask

    task automatic test_bad_ch();
        cmd(1, 1, OP_ON, 0);
        cmd(1, 1, OP_INC, 2);
        check_cnt++; if (bus1.dac_out !== 36'h000_020_000) $display("FAIL ch1_inc got %h want 000020000", bus1.dac_out); else pass_cnt++;
        cmd(1, 3, OP_ON, 0);
        check_cnt++; if (bus1.cmd_err !== 1'b1 || bus1.dac_out !== 36'h000_020_000 || bus1.no_order !== 1'b0)
            $display("FAIL badch_on got err=%0b dac=%h no_order=%0b want 1 000020000 0", bus1.cmd_err, bus1.dac_out, bus1.no_order); else pass_cnt++;
        cmd(1, 3, OP_RECV, 0);
        check_cnt++; if (bus1.cmd_err !== 1'b1 || bus1.act_ch !== 2'd0 || bus1.cap_count !== 8'd0)
            $display("FAIL badch_recv got err=%0b act=%0d count=%0d want 1 0 0", bus1.cmd_err, bus1.act_ch, bus1.cap_count); else pass_cnt++;
        cmd(1, 0, OP_NOP, 0);
        check_cnt++; if (bus1.cmd_err !== 1'b0 || bus1.dac_out !== 36'h000_020_000)
            $display("FAIL nop got err=%0b dac=%h want 0 000020000", bus1.cmd_err, bus1.dac_out); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        cmd(0, 0, OP_ON, 0);
        cmd(0, 0, OP_SEND, 0);
        check_cnt++; if (bus0.act_ch !== 2'd0 || bus0.sending !== 1'b1)
            $display("FAIL b2b_send0 got act=%0d sending=%0b want 0 1", bus0.act_ch, bus0.sending); else pass_cnt++;
        cmd(0, 1, OP_RECV, 0);
        check_cnt++; if (bus0.act_ch !== 2'd1 || bus0.sending !== 1'b0)
            $display("FAIL b2b_recv1 got act=%0d sending=%0b want 1 0", bus0.act_ch, bus0.sending); else pass_cnt++;
        cmd(0, 1, OP_SEND, 0);
        stream(0, 25'h1BEEF, 1);
        check_cnt++; if (bus0.axi_valid !== 1'b1 || bus0.axi_out !== 25'h1BEEF || bus0.cap_count !== 8'd1)
            $display("FAIL b2b_send1 got v=%0b axi=%h count=%0d want 1 1beef 1", bus0.axi_valid, bus0.axi_out, bus0.cap_count); else pass_cnt++;
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        bus0.cmd_valid = 1'b0; bus0.cmd_ch = '0; bus0.cmd_op = '0; bus0.cmd_amount = '0;
        bus0.buf_valid = 1'b0; bus0.buf_data = '0; bus0.rd_en = 1'b0; bus0.rd_addr = '0;
        bus1.cmd_valid = 1'b0; bus1.cmd_ch = '0; bus1.cmd_op = '0; bus1.cmd_amount = '0;
        bus1.buf_valid = 1'b0; bus1.buf_data = '0; bus1.rd_en = 1'b0; bus1.rd_addr = '0;
        test_reset();
        test_level();
        test_send();
        test_capture_stop();
        test_capture_wrap();
        test_reset_mid();
        test_bad_ch();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/ultrasonic_cu_mc.md
Name: ultrasonic_cu_mc

Overview:
- Multi-channel, parametrised successor of the ultrasonic control unit.
- Accepts per-channel commands: on, off, increase, decrease, send, receive, clear.
- Holds one saturating DAC drive level per channel.
- Routes buffer data either to the AXI output (send mode) or into a capture RAM readable over a registered read port (receive mode).
- Sits between the sample buffer, the per-channel DACs and the AXI register/read interface.

Parameters:
- N_CH, 4, number of transducer channels (CH_W = max(1, clog2(N_CH)))
- DATA_W, 25, buffer/AXI data width
- DAC_W, 12, DAC level width per channel
- AMT_W, 8, command amount width
- AMT_SHIFT, 4, left shift applied to amount before add/subtract
- DEPTH, 128, capture RAM entries (AW = clog2(DEPTH))
- WRAP, 0, 0 = stop capturing at full; 1 = circular overwrite

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command strobe, one command per cycle
- cmd_ch  in  CH_W  target channel
- cmd_op  in  3  opcode (NOP, ON, OFF, INC, DEC, SEND, RECV, CLEAR)
- cmd_amount  in  AMT_W  step for INC/DEC
- cmd_err  out  1  one-cycle pulse on a rejected command
- buf_valid  in  1  buffer sample valid
- buf_data  in  DATA_W  buffer sample
- axi_out  out  DATA_W  forwarded sample (send mode)
- axi_valid  out  1  axi_out valid pulse
- sending  out  1  the active channel is in SEND
- no_order  out  1  all channels OFF
- dac_out  out  N_CH*DAC_W  packed levels; channel k occupies bits [k*DAC_W +: DAC_W]
- act_ch  out  CH_W  channel owning the data path
- rd_en  in  1  capture read enable
- rd_addr  in  AW  capture read address
- rd_data  out  DATA_W  capture read data
- cap_count  out  AW+1  valid entries captured
- cap_full  out  1  cap_count == DEPTH
- cap_ovf  out  1  sticky: sample dropped (WRAP=0) or overwritten (WRAP=1)

Behaviour:
- Reset:
  - All channels OFF; levels 0; act_ch 0.
  - axi_out 0, axi_valid 0, sending 0, no_order 1, cmd_err 0.
  - rd_data 0; wr_ptr 0, cap_count 0, cap_ovf 0.
  - RAM contents are not cleared.
  - Reset mid-operation aborts any capture or send immediately.
- Per-channel FSM states: OFF, IDLE, SEND, RECV.
  - ON: OFF -> IDLE; ignored in other states.
  - OFF: any state -> OFF; level cleared to 0.
  - SEND/RECV: IDLE/SEND/RECV -> SEND/RECV; act_ch <= cmd_ch. The previous act_ch, if it is a different channel in SEND/RECV, returns to IDLE. At most one channel is ever in SEND/RECV.
  - SEND/RECV on an OFF channel -> cmd_err.
- Level arithmetic:
  - INC: level = min(level + (amount << AMT_SHIFT), 2^DAC_W - 1), computed at DAC_W+1 bits.
  - DEC: level = max(level - (amount << AMT_SHIFT), 0).
  - INC/DEC on an OFF channel -> cmd_err; level unchanged.
- Command rules:
  - cmd_ch >= N_CH -> cmd_err; no state change.
  - NOP with cmd_valid -> no effect, no error.
- Command timing:
  - Every command takes effect on the cycle after cmd_valid: dac_out, state, sending and no_order are all registered with 1-cycle latency.
  - A buffer sample in the same cycle as a command uses the pre-command state.
- Send path: buf_valid while the act_ch state is SEND -> next cycle axi_out = buf_data and axi_valid = 1. Otherwise axi_valid = 0 and axi_out holds its last value.
- Receive path: buf_valid while the act_ch state is RECV -> RAM[wr_ptr] = buf_data, wr_ptr increments modulo DEPTH.
  - WRAP=0: at cap_full the write is dropped and cap_ovf is set.
  - WRAP=1: the write always proceeds; cap_count saturates at DEPTH; when full, cap_ovf is set.
- CLEAR on any valid channel: wr_ptr, cap_count and cap_ovf <= 0. A simultaneous capture write is discarded.
- Read port:
  - rd_en -> rd_data = RAM[rd_addr] on the next cycle; rd_data holds when rd_en is low.
  - Read and write to the same address in the same cycle returns the old data (read-before-write).

Decomposition:
- Package cu_mc_pkg holds:
  - the opcode enum cu_op_t (NOP=0, ON=1, OFF=2, INC=3, DEC=4, SEND=5, RECV=6, CLEAR=7);
  - the channel state enum ch_state_t;
  - the DAC saturation constant function.
- Sub-module cu_capture_ram: simple dual-port RAM, DEPTH x DATA_W, one write port, one registered read port, read-before-write.

Test Plan:
- Reset -> no_order=1, dac_out=0, axi_valid=0, cap_count=0. Then ON ch1 -> next cycle no_order=0.
- ON ch0, INC amount=1 -> ch0 level 0x010. INC amount=0xFF twice -> 0xFFF (saturated). DEC amount=0xFF twice -> 0x000. OFF -> level 0x000.
- ON ch2, SEND ch2, buf_valid with 0x0FFFFFF -> next cycle axi_out=0x0FFFFFF, axi_valid=1, sending=1. Then SEND ch3 while ch3 is OFF -> cmd_err=1, act_ch stays 2.
- DEPTH=128, WRAP=0: RECV, 130 samples 0..129 -> cap_count=128, cap_full=1, cap_ovf=1. rd_addr=127 -> rd_data=127. CLEAR -> cap_count=0, cap_ovf=0.
- WRAP=1: 130 samples 0..129 -> RAM[0]=128, RAM[1]=129, cap_count=128, cap_ovf=1. Read of the address being written in the same cycle returns the prior value.
- Mid-capture rst pulse -> all outputs back to reset values. cmd_ch=N_CH -> cmd_err pulse with no state change.
